// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// default geometry and the HALT opcode the decode stage recognises.
package fetch_unit_pkg;

  localparam int          DEFAULT_PC_WIDTH    = 16;
  localparam int          DEFAULT_INSTR_WIDTH = 16;
  localparam logic [15:0] DEFAULT_RESET_PC    = 16'h0000;
  localparam logic [4:0]  HALT_OPCODE         = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_incr.sv
// Sequential-PC adder; wraps modulo 2^WIDTH by construction.
module fetch_unit_pc_incr #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2
);

  assign pc_plus2 = pc + WIDTH'(2);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding request to a variable-latency instruction
// memory, single-entry output register to decode, redirect/halt/error handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int                  INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_done,
  input  logic                   imem_err,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   halt,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc_plus2,
  output logic                   instr_valid,
  output logic                   halted,
  output logic                   err
);

  fetch_state_e        state_reg;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                kill_reg;
  logic                consume;
  logic                halt_consume;
  logic                slot_free;

  assign consume      = instr_valid & ~stall;
  assign halt_consume = consume & halt & (state_reg != ST_HALTED);
  assign slot_free    = ~instr_valid | ~stall;

  // Issue only when the output slot will be empty by the time data returns.
  assign imem_req  = ~rst & (state_reg == ST_IDLE) & slot_free & ~redirect & ~halt_consume;
  assign imem_addr = pc_reg;

  fetch_unit_pc_incr #(.WIDTH(PC_WIDTH)) u_pc_incr (
    .pc       (pc_reg),
    .pc_plus2 (pc_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      kill_reg    <= 1'b0;
      instr       <= '0;
      pc_plus2    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else if (state_reg != ST_HALTED) begin
      if (halt_consume) begin
        state_reg   <= ST_HALTED;
        halted      <= 1'b1;
        instr_valid <= 1'b0;
      end else if (redirect) begin
        pc_reg      <= redirect_pc;
        instr_valid <= 1'b0;
        if (redirect_pc[0]) begin
          err       <= 1'b1;
          halted    <= 1'b1;
          state_reg <= ST_HALTED;
        end else if (state_reg == ST_WAIT) begin
          // A response landing with the redirect is simply dropped; otherwise
          // remember to drop the one still in flight.
          if (imem_done) begin
            kill_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            kill_reg  <= 1'b1;
          end
        end
      end else begin
        if (consume) instr_valid <= 1'b0;
        if (state_reg == ST_IDLE) begin
          if (imem_req) state_reg <= ST_WAIT;
        end else if (imem_done) begin
          if (kill_reg) begin
            kill_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (imem_err) begin
            err         <= 1'b1;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
            state_reg   <= ST_HALTED;
          end else begin
            instr       <= imem_rdata;
            pc_plus2    <= pc_inc;
            instr_valid <= 1'b1;
            pc_reg      <= pc_inc;
            state_reg   <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the fetch stage and memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_done, imem_err;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall, redirect, halt;
  logic [15:0] redirect_pc;
  logic [15:0] instr, pc_plus2;
  logic        instr_valid, halted, err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_done   (imem_done),
    .imem_err    (imem_err),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr       (instr),
    .pc_plus2    (pc_plus2),
    .instr_valid (instr_valid),
    .halted      (halted),
    .err         (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what decode should see, and whether a fetch is in flight.
  logic [15:0] m_pc, m_instr, m_pp2;
  bit          m_valid, m_busy, m_stale, m_stopped, m_err;

  // Memory model: a single pending response with a countdown.
  bit          mem_pend;
  int          mem_cnt;
  logic [15:0] mem_addr;
  bit          mem_bad;
  int unsigned lat_min = 1, lat_max = 1, err_pct = 0;
  bit          err_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    case (a)
      16'h0000: w = 16'hC0A5;
      16'h0002: w = 16'h4123;
      16'h0010: w = 16'h0000;
      16'hFFFE: w = 16'h0800;
      default: begin
        w = a * 16'd37 + 16'h1234;
        if (w[15:11] == HALT_OPCODE) w[15] = 1'b1;
      end
    endcase
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    imem_done = 1'b0; imem_err = 1'b0; imem_rdata = 16'h0;
    #1;
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_instr",  32'(instr),       32'd0);
    check("rst_pp2",    32'(pc_plus2),    32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    check("rst_err",    32'(err),         32'd0);
    check("rst_req",    32'(imem_req),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 16'h0000; m_instr = 16'h0; m_pp2 = 16'h0;
    m_valid = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_stopped = 1'b0; m_err = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; err_next = 1'b0;
  endtask

  // One clock cycle: drive inputs at negedge, check settled outputs, advance model.
  task automatic cycle(input bit s, input bit r, input logic [15:0] rp, input bit h);
    bit          done, merr, consume, exp_req;
    logic [15:0] rdata;
    stall = s; redirect = r; redirect_pc = rp; halt = h;
    done = mem_pend && (mem_cnt == 1);
    if (done) begin
      rdata = mem_word(mem_addr);
      merr  = mem_bad;
    end else begin
      rdata = 16'($urandom);
      merr  = 1'($urandom);
    end
    imem_done = done; imem_rdata = rdata; imem_err = merr;
    consume = m_valid && !s;
    exp_req = !m_stopped && !m_busy && (!m_valid || !s) && !r && !(consume && h);
    #1;
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr",       32'(instr),       32'(m_instr));
    check("pc_plus2",    32'(pc_plus2),    32'(m_pp2));
    check("halted",      32'(halted),      32'(m_stopped));
    check("err",         32'(err),         32'(m_err));
    check("imem_req",    32'(imem_req),    32'(exp_req));
    if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_pc));

    if (done) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (exp_req) begin
      mem_pend = 1'b1;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
      mem_addr = m_pc;
      mem_bad  = err_next || ($urandom_range(99, 0) < err_pct);
      err_next = 1'b0;
    end

    if (!m_stopped) begin
      if (consume && h) begin
        m_stopped = 1'b1; m_valid = 1'b0;
      end else if (r) begin
        m_valid = 1'b0; m_pc = rp;
        if (rp[0]) begin
          m_stopped = 1'b1; m_err = 1'b1;
        end else if (m_busy) begin
          if (done) begin m_busy = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end
      end else begin
        if (consume) m_valid = 1'b0;
        if (exp_req) m_busy = 1'b1;
        else if (m_busy && done) begin
          m_busy = 1'b0;
          if (m_stale) m_stale = 1'b0;
          else if (merr) begin
            m_stopped = 1'b1; m_err = 1'b1; m_valid = 1'b0;
          end else begin
            m_instr = rdata; m_pp2 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rp;
    bit          rs, rr, rh;

    // 1-cycle memory streaming
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("first_instr", 32'(instr),    32'hC0A5);
    check("first_pp2",   32'(pc_plus2), 32'h0002);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // 3-cycle memory with decode stall
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && !m_valid; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("lat3_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    check("stall_hold_instr", 32'(instr),    32'hC0A5);
    check("stall_hold_pp2",   32'(pc_plus2), 32'h0002);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Redirect while a fetch at 0x0006 is outstanding
    do_reset();
    for (int i = 0; i < 80 && !(m_busy && m_pc == 16'h0006); i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("wait_at_6", 32'(imem_addr), 32'h0006);
    cycle(1'b0, 1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Misaligned redirect
    cycle(1'b0, 1'b1, 16'h0041, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("misalign_err",    32'(err),    32'd1);
    check("misalign_halted", 32'(halted), 32'd1);

    // HALT presented under stall, then consumed
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 20 && !m_valid; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    check("halt_word", 32'(instr), 32'h0000);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("halt_stalled", 32'(halted), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("halt_taken", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0080, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // PC wrap at 0xFFFE, then a memory error
    do_reset();
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b0);
    for (int i = 0; i < 20 && !m_valid; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    check("wrap_instr", 32'(instr),    32'h0800);
    check("wrap_pp2",   32'(pc_plus2), 32'h0000);
    err_next = 1'b1;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 20 && !m_stopped; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("memerr_err",    32'(err),    32'd1);
    check("memerr_halted", 32'(halted), 32'd1);

    // Random traffic
    do_reset();
    lat_min = 1; lat_max = 3; err_pct = 2;
    for (int i = 0; i < 3000; i++) begin
      if ((m_stopped && $urandom_range(7, 0) == 0) || $urandom_range(199, 0) == 0) begin
        do_reset();
      end else begin
        rs = ($urandom_range(2, 0) == 0);
        rr = ($urandom_range(19, 0) == 0);
        rp = 16'($urandom);
        if ($urandom_range(15, 0) != 0) rp[0] = 1'b0;
        rh = m_valid && ((m_instr[15:11] == HALT_OPCODE) || ($urandom_range(39, 0) == 0));
        cycle(rs, rr, rp, rh);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Presents one instruction word plus PC+2 to decode through a single-entry output register with valid/stall handshake.
- Accepts branch/jump redirects from downstream, and stops permanently on halt or fetch error.

Parameters:
PC_WIDTH, 16, width of PC and memory address
RESET_PC, 16'h0000, PC value loaded on reset
INSTR_WIDTH, 16, instruction word width

Ports:
clk  input  1  system clock
rst  input  1  reset
imem_req  output  1  instruction memory request strobe, one cycle per fetch
imem_addr  output  16  fetch address (current PC), valid while imem_req=1
imem_rdata  input  16  instruction returned by memory, valid when imem_done=1
imem_done  input  1  response strobe, earliest 1 cycle after imem_req
imem_err  input  1  memory error, qualified by imem_done
stall  input  1  decode cannot accept the instruction this cycle
redirect  input  1  taken branch/jump/jump-register from downstream
redirect_pc  input  16  new PC, qualified by redirect
halt  input  1  decode reports the presented instruction is HALT
instr  output  16  instruction to decode
pc_plus2  output  16  address of presented instruction + 2
instr_valid  output  1  instr/pc_plus2 valid
halted  output  1  fetch permanently stopped
err  output  1  sticky fetch error

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. Reset gives pc=RESET_PC, state=IDLE, instr_valid=0, instr=16'h0000, pc_plus2=16'h0000, halted=0, err=0, kill=0, imem_req=0.
- Consume event: instr_valid=1 and stall=0 at a rising edge. That edge empties the output register unless it reloads the register on the same edge.
- FSM states: IDLE, WAIT, HALTED.
- IDLE:
  - imem_req=1 (combinational) when the slot is free (instr_valid=0, or stall=0) and redirect=0 and halt-consume is not occurring; imem_addr=pc.
  - On an issue edge, go to WAIT.
  - imem_done is ignored in IDLE.
- WAIT:
  - imem_req=0.
  - On imem_done with kill=0 and imem_err=0: instr<=imem_rdata, pc_plus2<=pc+2, instr_valid<=1, pc<=pc+2, go to IDLE.
  - The slot is guaranteed empty at return, because issue only happens when the slot frees.
- Kill:
  - In WAIT, imem_done with kill=1 discards the data, clears kill, and returns to IDLE. pc is not incremented.
  - A redirect and imem_done on the same edge both apply: the data is discarded, pc<=redirect_pc, kill stays 0, go to IDLE.
- Throughput: one instruction per (memory latency + 1) cycles minimum. With 1-cycle memory: request at cycle N, done at N+1, instr_valid at N+2.
- Redirect (any state except HALTED):
  - pc<=redirect_pc and instr_valid<=0 (flush).
  - If in WAIT with no imem_done this cycle, set kill.
  - Redirect has priority over stall.
- Misaligned redirect: redirect_pc[0]=1 sets err<=1, halted<=1, state HALTED, instr_valid<=0.
- Halt: halt=1 on a consume event sets state HALTED, halted<=1, instr_valid<=0, and issues no further requests.
  - A response outstanding at that point is ignored.
  - Halt takes priority over a simultaneous redirect.
  - Halt with stall=1 has no effect until consumed.
- Memory error: imem_done with imem_err=1 (kill=0) sets err<=1, halted<=1, state HALTED, instr_valid<=0.
- HALTED is sticky until rst. imem_req=0; redirect, halt and imem_done are ignored.
- Arithmetic: pc+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000 with no error.
- Reset mid-WAIT: the outstanding response is dropped, since imem_done is ignored in IDLE.

Decomposition:
- Shared package: FSM state encodings (IDLE/WAIT/HALTED, 2-bit), PC_WIDTH, RESET_PC, HALT opcode 5'b00000 for bench use.
- One sub-module, pc_incr: 16-bit +2 adder producing pc_plus2, reused for the pc update.

Test Plan:
- Reset, 1-cycle memory returning 16'hC0A5, 16'h4123, stall=0 → requests at addresses 0, 2, 4; instr_valid pulses with instr=16'hC0A5/pc_plus2=2, then 16'h4123/pc_plus2=4; at most one request outstanding.
- 3-cycle memory latency, stall held 4 cycles after first instruction valid → instr and pc_plus2 held stable; no new imem_req until stall drops; next request at address 2.
- Redirect to 16'h0040 while in WAIT (response at 16'h0006 pending) → returned word discarded, instr_valid stays 0, next imem_addr=16'h0040.
- Redirect to 16'h0041 → err=1, halted=1, imem_req stays 0 forever, instr_valid=0.
- Present HALT (16'h0000) with stall=1 for 2 cycles then stall=0 → halted rises the edge after consume; later redirect/imem_done ignored; rst mid-HALTED restores pc=RESET_PC and fetch resumes.
- Redirect to 16'hFFFE, memory returns 16'h0800 → pc_plus2=16'h0000, next imem_addr=16'h0000; imem_err on a later response → err=1, halted=1.
